alu_issue_ctrl: RTL and testbench

- Operand-issue and writeback sequencer directly upstream of the 16-bit ripple ALU.
- Holds an 8x16 register file and accepts one instruction at a time over a valid/ready handshake.
- Reads rs/rt, translates the opcode into the ALU's 3-bit select, drives registered A/B/sel into the ALU, then captures the ALU result and writes it to rd.

---
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback sequencer in front of the 16-bit ripple ALU (IDLE -> ISSUE -> WB).
// Define ALU_ISSUE_OPCOUNT_EN to build the saturating retired-op counter on op_count.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       op_count
);

  localparam logic [2:0] OP_LOADI = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] rf_reg [NREGS];
  logic [ADDR_W-1:0] rd_reg;
  logic              loadi_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
  logic [2:0]        alu_sel_reg;
  logic              wb_valid_reg;
  logic [ADDR_W-1:0] wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              err_illegal_reg;

  logic              accept;
  logic              op_legal;
  logic [2:0]        sel_next;
  logic [DATA_W-1:0] rs_data, rt_data, wr_data;
  logic              wb_fire;

  // Opcode to ALU select; opcodes 6 and 7 have no mapping and are flagged illegal
  always_comb begin
    sel_next = 3'b000;
    op_legal = 1'b1;
    case (in_op)
      3'd0:    sel_next = 3'b000;
      3'd1:    sel_next = 3'b001;
      3'd2:    sel_next = 3'b010;
      3'd3:    sel_next = 3'b110;
      3'd4:    sel_next = 3'b111;
      3'd5:    sel_next = 3'b000;
      default: op_legal = 1'b0;
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;
  assign wb_fire  = (state_reg == WB);
  assign rs_data  = (in_rs == '0) ? '0 : rf_reg[in_rs];
  assign rt_data  = (in_rt == '0) ? '0 : rf_reg[in_rt];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_reg[dbg_addr];
  assign wr_data  = loadi_reg ? imm_reg : alu_out;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && op_legal) state_next = ISSUE;
      ISSUE:   state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg          <= '0;
      loadi_reg       <= 1'b0;
      imm_reg         <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_sel_reg     <= 3'b000;
      wb_valid_reg    <= 1'b0;
      wb_addr_reg     <= '0;
      wb_data_reg     <= '0;
      err_illegal_reg <= 1'b0;
    end else begin
      wb_valid_reg    <= wb_fire;
      err_illegal_reg <= accept && !op_legal;
      if (accept && op_legal) begin
        rd_reg      <= in_rd;
        loadi_reg   <= (in_op == OP_LOADI);
        imm_reg     <= in_imm;
        alu_a_reg   <= rs_data;
        alu_b_reg   <= rt_data;
        alu_sel_reg <= sel_next;
      end
      if (wb_fire) begin
        wb_addr_reg <= rd_reg;
        // r0 writes are dropped, so report the value r0 actually holds
        wb_data_reg <= (rd_reg == '0) ? '0 : wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
    end else if (wb_fire && rd_reg != '0) begin
      rf_reg[rd_reg] <= wr_data;
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_sel     = alu_sel_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_addr     = wb_addr_reg;
  assign wb_data     = wb_data_reg;
  assign err_illegal = err_illegal_reg;

`ifdef ALU_ISSUE_OPCOUNT_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 op_count_reg <= '0;
    else if (wb_fire && op_count_reg != 16'hFFFF) op_count_reg <= op_count_reg + 16'd1;
  end

  assign op_count = op_count_reg;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and reference register file.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [2:0]  in_rd = '0, in_rs = '0, in_rt = '0;
  logic [15:0] in_imm = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        err_illegal;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [15:0] op_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    bit          is_err;
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model[8];
  int          exp_cnt = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ripple ALU, behavioural
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a | alu_b;
      3'b010:  alu_out = alu_a + alu_b;
      3'b110:  alu_out = alu_a - alu_b;
      3'b111:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] imm);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      default: return imm;
    endcase
  endfunction

  function automatic logic [2:0] ref_sel(input logic [2:0] op);
    case (op)
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b110;
      3'd4:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: every wb_valid / err_illegal pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (wb_valid || err_illegal)) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_output: wb_valid=%0b err_illegal=%0b with nothing expected", wb_valid, err_illegal);
      end else begin
        e = sbq.pop_front();
        chk("err_illegal_pulse", err_illegal, e.is_err);
        chk("wb_valid_pulse", wb_valid, !e.is_err);
        if (!e.is_err) begin
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_data", wb_data, e.data);
          chk("wb_latency", cyc, e.cyc + 2);
        end else begin
          chk("err_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [15:0] imm, input bit hold,
                       output int acc_cyc);
    int          waited;
    exp_t        e;
    logic [15:0] a, b, res;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", waited);
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    a = model[rs];
    b = model[rt];
    e.cyc = acc_cyc;
    e.addr = rd;
    if (op >= 3'd6) begin
      e.is_err = 1'b1;
      e.data = '0;
    end else begin
      res = ref_result(op, a, b, imm);
      e.is_err = 1'b0;
      e.data = (rd == 3'd0) ? 16'd0 : res;
      if (rd != 3'd0) model[rd] = res;
      if (exp_cnt < 65535) exp_cnt++;
    end
    sbq.push_back(e);
    $display("cyc %0d: op=%0d rd=r%0d rs=r%0d rt=r%0d imm=0x%04h exp_data=0x%04h", acc_cyc, op, rd, rs, rt, imm, e.data);
    @(posedge clk);
    #1;
    if (op < 3'd6) begin
      chk("in_ready_busy", in_ready, 1'b0);
      chk("alu_sel", alu_sel, ref_sel(op));
      if (op != 3'd5) begin
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
      end
    end else begin
      chk("in_ready_after_illegal", in_ready, 1'b1);
    end
    if (!hold || op >= 3'd6) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || !in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: %0d writebacks still pending, in_ready=%0b", sbq.size(), in_ready);
      sbq.delete();
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, model[i]);
    end
  endtask

  task automatic check_count();
`ifdef ALU_ISSUE_OPCOUNT_EN
    chk("op_count", op_count, exp_cnt);
`else
    chk("op_count_tied", op_count, 16'd0);
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sbq.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_cnt = 0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_err_illegal", err_illegal, 1'b0);
    check_regs();
    check_count();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, c3;
    int gap;
    logic [2:0] op;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_alu_b", alu_b, 16'd0);
    chk("rst_alu_sel", alu_sel, 3'd0);
    chk("rst_wb_addr", wb_addr, 3'd0);
    chk("rst_wb_data", wb_data, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    check_count();
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd5, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b0, c0);
    issue(3'd5, 3'd2, 3'd0, 3'd0, 16'h0F0F, 1'b0, c0);
    issue(3'd2, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, c0);
    wait_idle();
    dbg_addr = 3'd3;
    #1;
    chk("add_r3_const", dbg_data, 16'h2143);
    check_count();
    issue(3'd3, 3'd4, 3'd2, 3'd1, 16'h0000, 1'b0, c0);
    issue(3'd3, 3'd5, 3'd1, 3'd1, 16'h0000, 1'b0, c0);
    issue(3'd7, 3'd5, 3'd1, 3'd2, 16'hAAAA, 1'b0, c0);
    wait_idle();
    check_regs();
    check_count();
    issue(3'd5, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0, c0);
    wait_idle();
    dbg_addr = 3'd0;
    #1;
    chk("r0_reads_zero", dbg_data, 16'd0);

    // in_valid held high across dependent ops: accepts every third clock
    issue(3'd2, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b1, c0);
    issue(3'd2, 3'd6, 3'd6, 3'd1, 16'h0000, 1'b1, c1);
    issue(3'd4, 3'd7, 3'd1, 3'd6, 16'h0000, 1'b1, c2);
    issue(3'd1, 3'd7, 3'd7, 3'd4, 16'h0000, 1'b1, c3);
    chk("accept_spacing_1", c1 - c0, 3);
    chk("accept_spacing_2", c2 - c1, 3);
    chk("accept_spacing_3", c3 - c2, 3);
    wait_idle();
    check_regs();
    check_count();

    // reset while ADD r6 sits in WB: write must be aborted
    issue(3'd2, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, c0);
    @(posedge clk);
    #1;
    apply_reset();
    @(negedge clk);
    dbg_addr = 3'd6;
    #1;
    chk("r6_after_abort", dbg_data, 16'd0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(6, 7));
      else                           op = 3'($urandom_range(0, 5));
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 1'($urandom_range(0, 1)), c0);
      gap = $urandom_range(0, 3);
      if (gap == 3) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (n % 30 == 29) begin
        wait_idle();
        check_regs();
        check_count();
      end
    end
    wait_idle();
    check_regs();
    check_count();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
